mem_arbiter: RTL and testbench

// Shares the single-ported RAM between the instruction-fetch requester and the

---
 rtl/mem_arbiter_if.sv | 15 +
 rtl/mem_arbiter.sv | 60 ++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM signals around the memory arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              iREN, dREN, dWEN, iwait, dwait, err;
   logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
   logic [DATA_W-1:0] dstore, iload, dload, ramstore, ramload;
   logic              ramREN, ramWEN, ram_ready, ram_error;
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready, ram_error,
      output iwait, dwait, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready, ram_error,
      input  iwait, dwait, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data, data first with anti-starvation
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input logic CLK,
   input logic nRST,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
   state_t            state, next_state;
   logic [SW-1:0]     starve_cnt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] store;
   logic              op_w, d_req, d_grant, i_grant, done, starved;
   assign d_req   = bus.dREN | bus.dWEN;
   assign starved = bus.iREN & (starve_cnt == SW'(STARVE_LIMIT));
   always_comb begin
      d_grant    = (state == IDLE) & d_req & ~starved;
      i_grant    = (state == IDLE) & ~d_grant & bus.iREN;
      done       = (state != IDLE) & (bus.ram_ready | bus.ram_error);
      next_state = d_grant ? DBUSY : i_grant ? IBUSY : done ? IDLE : state;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr       <= '0;
         store      <= '0;
         op_w       <= 1'b0;
      end else begin
         state <= next_state;
         if (d_grant) begin
            addr  <= bus.daddr;
            store <= bus.dstore;
            op_w  <= bus.dWEN;
         end else if (i_grant) begin
            addr  <= bus.iaddr;
            store <= '0;
            op_w  <= 1'b0;
         end
         // fetch waiting counts data wins; any fetch grant or idle fetch side resets it
         if (i_grant || (state == IDLE && !bus.iREN))
            starve_cnt <= '0;
         else if (d_grant && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
   assign bus.iwait    = bus.iREN & ~((state == IBUSY) & done);
   assign bus.dwait    = d_req & ~((state == DBUSY) & done);
   assign bus.iload    = (state == IBUSY && bus.ram_ready && !bus.ram_error) ? bus.ramload : '0;
   assign bus.dload    = (state == DBUSY && bus.ram_ready && !bus.ram_error) ? bus.ramload : '0;
   assign bus.err      = (done & bus.ram_error) | (d_grant & bus.dREN & bus.dWEN);
   assign bus.ramREN   = (state == IBUSY) | ((state == DBUSY) & ~op_w);
   assign bus.ramWEN   = (state == DBUSY) & op_w;
   assign bus.ramaddr  = addr;
   assign bus.ramstore = store;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner sequences and a randomized run against a transaction model
module tb_mem_arbiter;
   localparam int LIM = 4;
   logic CLK = 0, nRST = 0;
   int checks = 0, errors = 0;
   mem_arbiter_if #(32, 32) bus();
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
   always #5 CLK = ~CLK;

   typedef struct {
      logic ir, dr, dw;
      logic [31:0] ia, da, ds, rl;
      logic rr, re;
      logic eiw, edw;
      logic [31:0] eil, edl;
      logic eer, eren, ewen;
      logic [31:0] ea, es;
   } vec_t;
   vec_t tbl[$];

   // transaction model: owner 0 none, 1 fetch, 2 data
   int m_owner, m_starve;
   logic m_write, i_done, d_done;
   logic [31:0] m_addr, m_store;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic row(input logic ir, dr, dw, input logic [31:0] ia, da, ds, rl, input logic rr, re,
                      input logic eiw, edw, input logic [31:0] eil, edl, input logic eer, eren, ewen,
                      input logic [31:0] ea, es);
      tbl.push_back('{ir, dr, dw, ia, da, ds, rl, rr, re, eiw, edw, eil, edl, eer, eren, ewen, ea, es});
   endtask

   task automatic idle_inputs();
      bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.iaddr = 0; bus.daddr = 0;
      bus.dstore = 0; bus.ramload = 0; bus.ram_ready = 0; bus.ram_error = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1;
   endtask

   task automatic model_cycle();
      logic dreq, done, dg, ig;
      dreq = bus.dREN | bus.dWEN;
      done = m_owner != 0 && (bus.ram_ready || bus.ram_error);
      dg   = m_owner == 0 && dreq && !(bus.iREN && m_starve == LIM);
      ig   = m_owner == 0 && !dg && bus.iREN;
      chk("r_iwait", bus.iwait, bus.iREN && !(m_owner == 1 && done));
      chk("r_dwait", bus.dwait, dreq && !(m_owner == 2 && done));
      chk("r_iload", bus.iload, (m_owner == 1 && bus.ram_ready && !bus.ram_error) ? bus.ramload : 0);
      chk("r_dload", bus.dload, (m_owner == 2 && bus.ram_ready && !bus.ram_error) ? bus.ramload : 0);
      chk("r_err", bus.err, (done && bus.ram_error) || (dg && bus.dREN && bus.dWEN));
      chk("r_ramREN", bus.ramREN, m_owner == 1 || (m_owner == 2 && !m_write));
      chk("r_ramWEN", bus.ramWEN, m_owner == 2 && m_write);
      chk("r_ramaddr", bus.ramaddr, m_addr);
      chk("r_ramstore", bus.ramstore, m_store);
      i_done = bus.iREN && m_owner == 1 && done;
      d_done = dreq && m_owner == 2 && done;
      if (done) m_owner = 0;
      else if (dg) begin
         m_owner = 2; m_write = bus.dWEN; m_addr = bus.daddr; m_store = bus.dstore;
         m_starve = bus.iREN ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
      end else if (ig) begin
         m_owner = 1; m_write = 0; m_addr = bus.iaddr; m_store = 0; m_starve = 0;
      end else if (m_owner == 0 && !bus.iREN) m_starve = 0;
   endtask

   initial begin
      logic [31:0] g[$];
      int k;
      idle_inputs();
      #12;
      chk("rst_ramREN", bus.ramREN, 0);
      chk("rst_ramWEN", bus.ramWEN, 0);
      chk("rst_ramaddr", bus.ramaddr, 0);
      chk("rst_ramstore", bus.ramstore, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_starve", dut.starve_cnt, 0);

      // ir dr dw ia da ds rl rr re | iwait dwait iload dload err ramREN ramWEN ramaddr ramstore
      row(1,0,0,'h40,0,0,0,0,0,          1,0,0,0,0,0,0,0,0);
      row(1,0,0,'h40,0,0,0,0,0,          1,0,0,0,0,1,0,'h40,0);
      row(1,0,0,'h40,0,0,'hDEAD,1,0,     0,0,'hDEAD,0,0,1,0,'h40,0);
      row(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,'h40,0);
      row(1,0,1,'h44,'h80,'h1234,0,0,0,  1,1,0,0,0,0,0,'h40,0);
      row(1,0,1,'h44,'h80,'h1234,0,0,0,  1,1,0,0,0,0,1,'h80,'h1234);
      row(1,0,1,'h44,'h80,'h1234,0,1,0,  1,0,0,0,0,0,1,'h80,'h1234);
      row(1,0,0,'h44,0,0,0,0,0,          1,0,0,0,0,0,0,'h80,'h1234);
      row(1,0,0,'h44,0,0,'hCAFE,1,0,     0,0,'hCAFE,0,0,1,0,'h44,0);
      row(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,'h44,0);
      row(0,1,0,0,'h100,0,0,0,0,         0,1,0,0,0,0,0,'h44,0);
      row(0,1,0,0,'h100,0,0,0,0,         0,1,0,0,0,1,0,'h100,0);
      row(0,1,0,0,'h100,0,'hBEEF,1,1,    0,0,0,0,1,1,0,'h100,0);
      row(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,'h100,0);
      row(0,1,1,0,'h200,'h55,0,0,0,      0,1,0,0,1,0,0,'h100,0);
      row(0,1,1,0,'h200,'h55,0,0,0,      0,1,0,0,0,0,1,'h200,'h55);
      row(0,1,1,0,'h200,'h55,0,1,0,      0,0,0,0,0,0,1,'h200,'h55);
      row(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,'h200,'h55);
      row(0,1,0,0,'h300,0,0,0,0,         0,1,0,0,0,0,0,'h200,'h55);
      row(0,1,0,0,'h999,0,'h1111,1,0,    0,0,0,'h1111,0,1,0,'h300,0);
      row(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0,0,'h300,0);
      do_reset();
      foreach (tbl[i]) begin
         bus.iREN = tbl[i].ir; bus.dREN = tbl[i].dr; bus.dWEN = tbl[i].dw;
         bus.iaddr = tbl[i].ia; bus.daddr = tbl[i].da; bus.dstore = tbl[i].ds;
         bus.ramload = tbl[i].rl; bus.ram_ready = tbl[i].rr; bus.ram_error = tbl[i].re;
         @(negedge CLK);
         chk($sformatf("v%0d_iwait", i), bus.iwait, tbl[i].eiw);
         chk($sformatf("v%0d_dwait", i), bus.dwait, tbl[i].edw);
         chk($sformatf("v%0d_iload", i), bus.iload, tbl[i].eil);
         chk($sformatf("v%0d_dload", i), bus.dload, tbl[i].edl);
         chk($sformatf("v%0d_err", i), bus.err, tbl[i].eer);
         chk($sformatf("v%0d_ramREN", i), bus.ramREN, tbl[i].eren);
         chk($sformatf("v%0d_ramWEN", i), bus.ramWEN, tbl[i].ewen);
         chk($sformatf("v%0d_ramaddr", i), bus.ramaddr, tbl[i].ea);
         chk($sformatf("v%0d_ramstore", i), bus.ramstore, tbl[i].es);
         @(posedge CLK); #1;
      end

      // data held against pending fetch: four data grants, then the fetch is forced
      do_reset();
      bus.iREN = 1; bus.dREN = 1; bus.iaddr = 'hA0; bus.daddr = 'hD0; bus.ram_ready = 1;
      for (int c = 0; c < 40 && g.size() < 5; c++) begin
         @(negedge CLK);
         if (bus.ramREN) begin
            g.push_back(bus.ramaddr);
            if (bus.ramaddr == 'hA0) chk("starve_cleared", dut.starve_cnt, 0);
         end else if (g.size() == 4) chk("starve_full", dut.starve_cnt, LIM);
      end
      chk("starve_grants", g.size(), 5);
      for (int i = 0; i < g.size(); i++) chk($sformatf("starve_g%0d", i), g[i], i < 4 ? 'hD0 : 'hA0);
      @(posedge CLK); #1 idle_inputs();

      // reset during a data write drops strobes at once without completion or err
      do_reset();
      bus.iREN = 1; bus.dWEN = 1; bus.daddr = 'h500; bus.dstore = 'h77;
      @(negedge CLK);
      chk("mr_dwait_idle", bus.dwait, 1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("mr_ramWEN_busy", bus.ramWEN, 1);
      chk("mr_ramaddr", bus.ramaddr, 'h500);
      chk("mr_starve1", dut.starve_cnt, 1);
      #2 bus.ram_ready = 1; nRST = 0;
      #1;
      chk("mr_ramWEN", bus.ramWEN, 0);
      chk("mr_ramREN", bus.ramREN, 0);
      chk("mr_err", bus.err, 0);
      chk("mr_dwait", bus.dwait, 1);
      chk("mr_starve0", dut.starve_cnt, 0);
      @(posedge CLK); #1 nRST = 1; idle_inputs();

      // randomized traffic with requesters honouring the hold-until-done protocol
      do_reset();
      m_owner = 0; m_starve = 0; m_write = 0; m_addr = 0; m_store = 0; i_done = 0; d_done = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!bus.iREN || i_done) bus.iREN = $urandom_range(0, 99) < 45;
         else if ($urandom_range(0, 99) < 3) bus.iREN = 0;
         if (!(bus.dREN || bus.dWEN) || d_done) begin
            k = $urandom_range(0, 99);
            bus.dREN = k < 30; bus.dWEN = k >= 25 && k < 55;
         end else if ($urandom_range(0, 99) < 3) begin
            bus.dREN = 0; bus.dWEN = 0;
         end
         bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom; bus.ramload = $urandom;
         bus.ram_ready = (m_owner != 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
         bus.ram_error = $urandom_range(0, 99) < 6;
         @(negedge CLK);
         model_cycle();
         @(posedge CLK); #1;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
